jk_reg_bank: RTL

- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit bank of JK flip-flops on one clock.
- Each bit has its own J/K inputs and its own synchronous active-low preset and clear.
- The bank also has whole-bank modes: JK, binary count-up, serial shift-left and parallel load.
- It is the lab-level building block for registers, counters and shifters.
- Replaces ad-hoc arrays of single-bit JK cells, with the illegal preset+clear case defined instead of driven to X.

---
 rtl/jk_reg_bank.sv | 86 ++++++++
 1 files changed

// File: rtl/jk_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jk_reg_bank: WIDTH-bit JK flip-flop bank with count/shift/load modes,    |
// | per-bit sync preset/clear. Define JK_BANK_DOWN_EN for mode 11 count-down.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module jk_reg_bank #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] prn_v,
   input  logic [WIDTH-1:0] clrn_v,
   input  logic             sin,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             tc,
   output logic             err
);

   localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_q, q_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] w_nq;
   logic [WIDTH-1:0] w_conf;

   always_comb begin
      w_nq = q_q;
      if (en) begin
         case (mode)
            2'b00:   w_nq = (j & ~q_q) | (~k & q_q);
            2'b01:   w_nq = q_q + c_ONE;
            2'b10:   w_nq = {q_q[WIDTH-2:0], sin};
`ifdef JK_BANK_DOWN_EN
            default: w_nq = q_q - c_ONE;
`else
            default: w_nq = j;
`endif
         endcase
      end
   end

   // Overrides act on nq per bit; a preset+clear conflict keeps the pre-edge bit.
   always_comb begin
      w_conf = ~prn_v & ~clrn_v;
      q_d    = (w_nq & prn_v & clrn_v) | (~prn_v & clrn_v) | (q_q & w_conf);
      err_d  = err_q;
      if (|w_conf) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         q_q   <= RESET_VAL;
         err_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      tc = en && (mode == 2'b01) && (&q_q);
`ifdef JK_BANK_DOWN_EN
      if (en && (mode == 2'b11) && (q_q == '0)) begin
         tc = 1'b1;
      end
`endif
   end

   assign q   = q_q;
   assign qn  = ~q_q;
   assign err = err_q;

endmodule
`default_nettype wire
